// File: rtl/vga_pkg.sv
// Shared VGA timing types, the legacy 800x600 constants, and the timing-set validity check.
// Contents: VGA_CNT_W, vga_timing_t, VGA_TIMING_800x600, VGA_TIMING_640x480, between(), timing_valid().
// Macro VGA_SYNC_POL_EN adds per-axis sync polarity fields (h_pol, v_pol) to vga_timing_t.
package vga_pkg;

   localparam int VGA_CNT_W = 11;

   // Legacy fixed 800x600@40 MHz timing (SVGA, 40 MHz pixel clock).
   localparam int HOR_BLANK_START = 800;
   localparam int HOR_SYNC_START  = 840;
   localparam int HOR_SYNC_TIME   = 128;
   localparam int HOR_TOTAL_TIME  = 1056;
   localparam int VER_BLANK_START = 600;
   localparam int VER_SYNC_START  = 601;
   localparam int VER_SYNC_TIME   = 4;
   localparam int VER_TOTAL_TIME  = 628;

   typedef struct packed {
`ifdef VGA_SYNC_POL_EN
      logic                 h_pol;
      logic                 v_pol;
`endif
      logic [VGA_CNT_W-1:0] h_pix;
      logic [VGA_CNT_W-1:0] h_ss;
      logic [VGA_CNT_W-1:0] h_se;
      logic [VGA_CNT_W-1:0] h_tot;
      logic [VGA_CNT_W-1:0] v_pix;
      logic [VGA_CNT_W-1:0] v_ss;
      logic [VGA_CNT_W-1:0] v_se;
      logic [VGA_CNT_W-1:0] v_tot;
   } vga_timing_t;

   localparam vga_timing_t VGA_TIMING_800x600 = '{
`ifdef VGA_SYNC_POL_EN
      h_pol: 1'b1,
      v_pol: 1'b1,
`endif
      h_pix: VGA_CNT_W'(HOR_BLANK_START),
      h_ss:  VGA_CNT_W'(HOR_SYNC_START),
      h_se:  VGA_CNT_W'(HOR_SYNC_START + HOR_SYNC_TIME),
      h_tot: VGA_CNT_W'(HOR_TOTAL_TIME),
      v_pix: VGA_CNT_W'(VER_BLANK_START),
      v_ss:  VGA_CNT_W'(VER_SYNC_START),
      v_se:  VGA_CNT_W'(VER_SYNC_START + VER_SYNC_TIME),
      v_tot: VGA_CNT_W'(VER_TOTAL_TIME)
   };

   localparam vga_timing_t VGA_TIMING_640x480 = '{
`ifdef VGA_SYNC_POL_EN
      h_pol: 1'b0,
      v_pol: 1'b0,
`endif
      h_pix: VGA_CNT_W'(640),
      h_ss:  VGA_CNT_W'(656),
      h_se:  VGA_CNT_W'(752),
      h_tot: VGA_CNT_W'(800),
      v_pix: VGA_CNT_W'(480),
      v_ss:  VGA_CNT_W'(490),
      v_se:  VGA_CNT_W'(492),
      v_tot: VGA_CNT_W'(525)
   };

   // lo <= val < hi, one bit wider than a count so tot+1 cannot overflow.
   function automatic logic between(input logic [VGA_CNT_W:0] val,
                                    input logic [VGA_CNT_W:0] lo,
                                    input logic [VGA_CNT_W:0] hi);
      return (val >= lo) && (val < hi);
   endfunction

   // pix < ss < se <= tot on both axes, and at least two positions per axis.
   function automatic logic timing_valid(input vga_timing_t t);
      localparam logic [VGA_CNT_W:0] ONE = 1;
      localparam logic [VGA_CNT_W-1:0] TWO = 2;
      logic h_ok;
      logic v_ok;
      h_ok = between({1'b0, t.h_ss}, {1'b0, t.h_pix} + ONE, {1'b0, t.h_se})
          && between({1'b0, t.h_se}, {1'b0, t.h_ss} + ONE, {1'b0, t.h_tot} + ONE)
          && (t.h_tot >= TWO);
      v_ok = between({1'b0, t.v_ss}, {1'b0, t.v_pix} + ONE, {1'b0, t.v_se})
          && between({1'b0, t.v_se}, {1'b0, t.v_ss} + ONE, {1'b0, t.v_tot} + ONE)
          && (t.v_tot >= TWO);
      return h_ok && v_ok;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// Single-axis position counter with registered blank/sync flags derived from the next count.
// Ports: en_i advances the count; tot_i is the live axis length; pix_i/ss_i/se_i are the thresholds
// for the next cycle; cnt_o/blnk_o/sync_o are cycle-aligned; wrap_o is high on an enabled last position.
module vga_axis_cnt
   import vga_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic [VGA_CNT_W-1:0] tot_i,
   input  logic [VGA_CNT_W-1:0] pix_i,
   input  logic [VGA_CNT_W-1:0] ss_i,
   input  logic [VGA_CNT_W-1:0] se_i,
   output logic [VGA_CNT_W-1:0] cnt_o,
   output logic                 blnk_o,
   output logic                 sync_o,
   output logic                 wrap_o
);

   localparam logic [VGA_CNT_W-1:0] ONE = 1;

   logic [VGA_CNT_W-1:0] cnt_q, cnt_d;
   logic                 blnk_q, blnk_d;
   logic                 sync_q, sync_d;
   logic                 at_end;

   // Kept apart from the flag logic: the parent feeds wrap_o back into the
   // threshold mux (commit), so these must not share a block with blnk_d/sync_d.
   assign at_end = (cnt_q == tot_i - ONE);
   assign wrap_o = en_i && at_end;

   // Thresholds already reflect a commit on this cycle, so the first count of
   // a new frame is flagged against the new timing set.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = at_end ? '0 : cnt_q + ONE;
      end
      blnk_d = (cnt_d >= pix_i);
      sync_d = (cnt_d >= ss_i) && (cnt_d < se_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         blnk_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         blnk_q <= blnk_d;
         sync_q <= sync_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign blnk_o = blnk_q;
   assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_prog.sv
// Programmable VGA timing generator: counts, sync, blank from a shadowed timing set committed at frame end.
// Latency: flags cycle-aligned with counts; an accepted set goes live on the cycle after the next last pixel.
// Backpressure: cfg_ready = !cfg_pending; offers are ignored while a set waits for commit.
// Ports: clk/rst (sync, active-high); cfg_valid/cfg_timing/cfg_ready/cfg_err/cfg_pending config handshake;
// hcount/vcount/hsync/vsync/hblnk/vblnk/frame_start/frame_cnt to the draw pipeline.
// Macro VGA_SYNC_POL_EN: sync outputs follow the committed h_pol/v_pol (1 = active-high).
module vga_timing_prog
   import vga_pkg::*;
#(
   parameter vga_timing_t DEF_TIMING  = VGA_TIMING_800x600,
   parameter int          FRAME_CNT_W = 16
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_valid,
   input  logic [$bits(vga_timing_t)-1:0] cfg_timing,
   output logic                           cfg_ready,
   output logic                           cfg_err,
   output logic                           cfg_pending,
   output logic [VGA_CNT_W-1:0]           hcount,
   output logic [VGA_CNT_W-1:0]           vcount,
   output logic                           hsync,
   output logic                           vsync,
   output logic                           hblnk,
   output logic                           vblnk,
   output logic                           frame_start,
   output logic [FRAME_CNT_W-1:0]         frame_cnt
);

   localparam logic [FRAME_CNT_W-1:0] FC_ONE = 1;

   vga_timing_t            act_q, act_d;
   vga_timing_t            shadow_q, shadow_d;
   vga_timing_t            cfg_t;
   logic                   pending_q, pending_d;
   logic                   err_q, err_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   h_wrap, last_pix;
   logic                   xfer, commit;
   logic                   hsync_raw, vsync_raw;

   assign cfg_t = vga_timing_t'(cfg_timing);

   always_comb begin
      xfer        = cfg_valid && !pending_q;
      // A set accepted on the last-pixel cycle has pending_q=0 here, so it
      // waits for the following frame end.
      commit      = last_pix && pending_q;
      act_d       = commit ? shadow_q : act_q;
      shadow_d    = shadow_q;
      pending_d   = pending_q;
      err_d       = 1'b0;
      frame_cnt_d = last_pix ? frame_cnt_q + FC_ONE : frame_cnt_q;
      if (commit) begin
         pending_d = 1'b0;
      end
      if (xfer) begin
         if (timing_valid(cfg_t)) begin
            shadow_d  = cfg_t;
            pending_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_q       <= DEF_TIMING;
         shadow_q    <= DEF_TIMING;
         pending_q   <= 1'b0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         act_q       <= act_d;
         shadow_q    <= shadow_d;
         pending_q   <= pending_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Wrap decisions use the live set; flag thresholds use the set that will
   // be live next cycle.
   vga_axis_cnt u_h (
      .clk    (clk),
      .rst    (rst),
      .en_i   (1'b1),
      .tot_i  (act_q.h_tot),
      .pix_i  (act_d.h_pix),
      .ss_i   (act_d.h_ss),
      .se_i   (act_d.h_se),
      .cnt_o  (hcount),
      .blnk_o (hblnk),
      .sync_o (hsync_raw),
      .wrap_o (h_wrap)
   );

   vga_axis_cnt u_v (
      .clk    (clk),
      .rst    (rst),
      .en_i   (h_wrap),
      .tot_i  (act_q.v_tot),
      .pix_i  (act_d.v_pix),
      .ss_i   (act_d.v_ss),
      .se_i   (act_d.v_se),
      .cnt_o  (vcount),
      .blnk_o (vblnk),
      .sync_o (vsync_raw),
      .wrap_o (last_pix)
   );

`ifdef VGA_SYNC_POL_EN
   // Polarity comes from the registered active set, which switches on the
   // same edge as the counts wrap, so no skew is introduced.
   assign hsync = hsync_raw ^ ~act_q.h_pol;
   assign vsync = vsync_raw ^ ~act_q.v_pol;
`else
   assign hsync = hsync_raw;
   assign vsync = vsync_raw;
`endif

   assign frame_start = (hcount == '0) && (vcount == '0);
   assign frame_cnt   = frame_cnt_q;
   assign cfg_pending = pending_q;
   assign cfg_ready   = !pending_q;
   assign cfg_err     = err_q;

endmodule

// File: doc/vga_timing_prog.md
Name: vga_timing_prog

Overview:
- Programmable VGA timing generator; successor to the fixed 800x600@40 MHz timing.
- Produces hcount/vcount, sync and blanking from a runtime-loadable timing set.
- The timing set is held in a shadow register and committed only at the frame boundary, so a mode change never produces a torn frame.
- Sits between the clock/reset block and the draw pipeline (background, rect, font stages), which consume its counts and flags.

Parameters:
- DEF_TIMING, vga_pkg::VGA_TIMING_800x600, reset-time active timing: h_pix=800, h_ss=840, h_se=968, h_tot=1056, v_pix=600, v_ss=601, v_se=605, v_tot=628.
- FRAME_CNT_W, 16, width of the free-running frame counter.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  new timing set offered.
- cfg_timing  in  $bits(vga_timing_t)  offered timing set.
- cfg_ready  out  1  shadow slot free.
- cfg_err  out  1  one-cycle pulse: accepted set was invalid and discarded.
- cfg_pending  out  1  shadow holds a set awaiting commit.
- hcount  out  11  horizontal position.
- vcount  out  11  vertical position.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- hblnk  out  1  horizontal blank.
- vblnk  out  1  vertical blank.
- frame_start  out  1  high while hcount==0 && vcount==0.
- frame_cnt  out  FRAME_CNT_W  completed-frame counter.

Behaviour:
- Reset (synchronous, active-high):
  - active timing = DEF_TIMING; hcount=vcount=0.
  - hsync=vsync=hblnk=vblnk=0; frame_start=1; frame_cnt=0.
  - cfg_pending=0, cfg_ready=1, cfg_err=0.
- Counting:
  - hcount runs 0..h_tot-1, then wraps to 0.
  - vcount increments when hcount wraps; vcount wraps after v_tot-1.
- Flags are registered from the next-count value, so every flag is cycle-aligned with the count it describes (zero skew between counts and flags):
  - hblnk = hcount>=h_pix
  - hsync = h_ss<=hcount<h_se
  - vblnk and vsync use the same rules on vcount with v_pix, v_ss, v_se.
- Last pixel of a frame: hcount==h_tot-1 && vcount==v_tot-1.
  - frame_cnt increments on that cycle; wraps modulo 2^FRAME_CNT_W.
- Configuration handshake:
  - cfg_ready = !cfg_pending; a transfer happens on cfg_valid && cfg_ready.
  - A set is valid iff x_pix < x_ss < x_se <= x_tot for both axes and h_tot>=2, v_tot>=2.
  - Valid set: captured into shadow; cfg_pending=1 on the next cycle.
  - Invalid set: not captured; cfg_err pulses for one cycle on the next cycle; cfg_pending stays unchanged.
- Commit:
  - On the last-pixel cycle with cfg_pending=1, shadow is copied to active and cfg_pending clears.
  - On the following cycle the counts are 0/0 and all comparisons use the new set.
- Boundary cases:
  - Transfer on the same cycle as the last pixel: not committed at this boundary (pending was 0); it commits at the following frame end.
  - While pending, cfg_valid is ignored; the sender must hold its offer.
  - rst mid-frame or mid-pending: shadow is discarded and the generator returns to DEF_TIMING.
  - The new set shorter than the current counts is never an issue, because commit only occurs when the counts wrap to 0.

Optional Feature:
- Macro: VGA_SYNC_POL_EN.
- Defined:
  - vga_timing_t gains fields h_pol and v_pol; they are committed with the rest of the set.
  - hsync/vsync outputs = raw sync XOR ~pol, so pol=1 means active-high.
  - DEF_TIMING uses pol=1,1.
  - Reset output value is the inactive level (~pol).
- Not defined:
  - No pol fields; sync outputs are always active-high.

Decomposition:
- vga_pkg gains:
  - VGA_CNT_W=11.
  - packed struct vga_timing_t: h_pix, h_ss, h_se, h_tot, v_pix, v_ss, v_se, v_tot, each VGA_CNT_W bits, plus pol fields under the macro.
  - constants VGA_TIMING_800x600 (from the existing HOR_/VER_ constants) and VGA_TIMING_640x480 (640/656/752/800, 480/490/492/525).
  - function timing_valid(vga_timing_t), reusing the existing between().
- One sub-module: vga_axis_cnt. It is a single-axis counter plus flag generator, instantiated twice (h and v), with the v instance enabled by the h wrap.

Test Plan:
- Reset, then run 1 frame with defaults:
  - hsync high for hcount 840..967 (128 cycles/line).
  - vsync high on lines 601..604.
  - Last pixel at cycle 663167; frame_cnt=1 after 663168 cycles.
- Offer VGA_TIMING_640x480 mid-frame:
  - cfg_ready drops the next cycle.
  - Current frame keeps h_tot=1056.
  - The next frame has 800-cycle lines and 525 lines.
  - cfg_pending clears at commit.
- Offer a set with h_ss=700 < h_pix=800:
  - cfg_err pulses for 1 cycle.
  - cfg_pending stays 0; timing is unchanged.
- Transfer exactly on the last-pixel cycle:
  - No commit at this wrap; commit at the following frame end.
- Assert rst while cfg_pending=1 and hcount=500:
  - Next cycle: counts 0, DEF_TIMING active, cfg_pending=0.
- With VGA_SYNC_POL_EN and pol=0,0 committed:
  - hsync/vsync are low during the sync windows and high elsewhere.
